// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment encoder/decoder pair:
// active-low glyph codes (bit order g..a), the blank pattern, and the
// scan FSM state encoding.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h18;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h27;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational glyph recogniser: maps an active-low 7-bit segment
// pattern back to its hex value. hit flags a legal glyph, blank flags
// the all-off pattern; anything else is neither.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       hit,
    output logic       blank,
    output logic [3:0] value
);

    // Reverse lookup of the shared glyph table
    always_comb begin
        hit   = 1'b1;
        blank = 1'b0;
        value = 4'h0;
        case (pattern)
            SEG_0:     value = 4'h0;
            SEG_1:     value = 4'h1;
            SEG_2:     value = 4'h2;
            SEG_3:     value = 4'h3;
            SEG_4:     value = 4'h4;
            SEG_5:     value = 4'h5;
            SEG_6:     value = 4'h6;
            SEG_7:     value = 4'h7;
            SEG_8:     value = 4'h8;
            SEG_9:     value = 4'h9;
            SEG_A:     value = 4'hA;
            SEG_B:     value = 4'hB;
            SEG_C:     value = 4'hC;
            SEG_D:     value = 4'hD;
            SEG_E:     value = 4'hE;
            SEG_F:     value = 4'hF;
            SEG_BLANK: begin
                hit   = 1'b0;
                blank = 1'b1;
            end
            default:   hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed active-low seven-segment bus and recovers the hex
// value and decimal point of each digit. A digit is captured once its
// {dig_sel, seg_in} value has been identical for STABLE_CYCLES
// consecutive comparisons, then not recaptured until the bus changes.
// fsm_state exposes the scan FSM for observation.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_en,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] digit_val,
    output logic [NUM_DIGITS-1:0]   dp_val,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   bad_pattern,
    output logic                    update,
    output logic [2:0]              update_idx,
    output logic [1:0]              fsm_state
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    scan_state_t           state;
    scan_state_t           state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [NUM_DIGITS-1:0] prev_sel;
    logic [7:0]            prev_seg;
    logic                  same;
    logic                  sel_ok;
    logic                  capture;
    logic [2:0]            sel_idx;
    logic                  dec_hit;
    logic                  dec_blank;
    logic [3:0]            dec_val;

    assign same      = (dig_sel == prev_sel) && (seg_in == prev_seg);
    assign sel_ok    = sample_en && $onehot(dig_sel);
    assign fsm_state = state;

    seg_pattern_decode u_decode (
        .pattern (seg_in[6:0]),
        .hit     (dec_hit),
        .blank   (dec_blank),
        .value   (dec_val)
    );

    // One-hot digit select to binary index
    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_sel[i]) sel_idx = 3'(i);
        end
    end

    // Bus history used to detect a stable sample
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sel <= '0;
            prev_seg <= '0;
        end else begin
            prev_sel <= dig_sel;
            prev_seg <= seg_in;
        end
    end

    // FSM state and stability counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: settle, capture once, hold until the bus moves
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (sel_ok) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                end
            end
            SETTLE: begin
                if (!sel_ok) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (!same) begin
                    cnt_nxt = '0;
                end else if (cnt == LAST_CNT) begin
                    capture   = 1'b1;
                    state_nxt = HELD;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!sel_ok) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (!same) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Per-digit storage; only the selected digit changes on a capture.
    // A new bad capture overrides a simultaneous err_clr for its digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_val   <= '0;
            dp_val      <= '0;
            digit_valid <= '0;
            bad_pattern <= '0;
            update      <= 1'b0;
            update_idx  <= 3'd0;
        end else begin
            update <= capture;
            if (err_clr) bad_pattern <= '0;
            if (capture) update_idx <= sel_idx;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && (sel_idx == 3'(i))) begin
                    dp_val[i] <= ~seg_in[7];
                    if (dec_hit) begin
                        digit_val[4*i +: 4] <= dec_val;
                        digit_valid[i]      <= 1'b1;
                    end else begin
                        digit_valid[i] <= 1'b0;
                        if (!dec_blank) bad_pattern[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios plus a randomized run,
// all checked against a run-length reference model of the snooped bus.
module tb_seg_scan_decoder;
    import seg_pkg::*;

    localparam int N = 6;
    localparam int S = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           sample_en;
    logic [7:0]     seg_in;
    logic [N-1:0]   dig_sel;
    logic           err_clr;
    logic [4*N-1:0] digit_val;
    logic [N-1:0]   dp_val;
    logic [N-1:0]   digit_valid;
    logic [N-1:0]   bad_pattern;
    logic           update;
    logic [2:0]     update_idx;
    logic [1:0]     fsm_state;

    seg_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (sample_en),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .err_clr     (err_clr),
        .digit_val   (digit_val),
        .dp_val      (dp_val),
        .digit_valid (digit_valid),
        .bad_pattern (bad_pattern),
        .update      (update),
        .update_idx  (update_idx),
        .fsm_state   (fsm_state)
    );

    logic [45:0] dut_vec;
    assign dut_vec = {digit_val, dp_val, digit_valid, bad_pattern, update, update_idx};

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
    logic [3:0]   m_val [N];
    logic [N-1:0] m_dp, m_valid, m_bad;
    logic         m_upd;
    logic [2:0]   m_idx;
    int           run;       // consecutive qualified edges with identical bus
    logic [N+7:0] m_prev;

    function automatic logic [45:0] exp_vec();
        logic [4*N-1:0] dv;
        for (int i = 0; i < N; i++) dv[4*i +: 4] = m_val[i];
        return {dv, m_dp, m_valid, m_bad, m_upd, m_idx};
    endfunction

    task automatic model_edge();
        logic         ok;
        logic [N+7:0] bus;
        int           idx;
        int           val;
        if (rst) begin
            for (int i = 0; i < N; i++) m_val[i] = 4'h0;
            m_dp = '0; m_valid = '0; m_bad = '0; m_upd = 1'b0; m_idx = 3'd0;
            run = 0; m_prev = '0;
        end else begin
            ok  = sample_en && ($countones(dig_sel) == 1);
            bus = {dig_sel, seg_in};
            if (!ok) run = 0;
            else if (run == 0 || bus != m_prev) run = 1;
            else if (run < 1000) run++;
            m_upd = 1'b0;
            if (err_clr) m_bad = '0;
            if (ok && run == S + 1) begin
                idx = 0;
                for (int i = 0; i < N; i++) if (dig_sel[i]) idx = i;
                val = -1;
                for (int g = 0; g < 16; g++) if (glyph[g] == seg_in[6:0]) val = g;
                m_upd      = 1'b1;
                m_idx      = 3'(idx);
                m_dp[idx]  = ~seg_in[7];
                if (val >= 0) begin
                    m_val[idx]   = 4'(val);
                    m_valid[idx] = 1'b1;
                end else begin
                    m_valid[idx] = 1'b0;
                    if (seg_in[6:0] != 7'h7F) m_bad[idx] = 1'b1;
                end
            end
            m_prev = bus;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [N-1:0] sel, input logic [7:0] seg,
                         input logic en, input logic clr);
        dig_sel   = sel;
        seg_in    = seg;
        sample_en = en;
        err_clr   = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(6'b000100, 8'h19, 1'b1, 1'b0);
        for (int t = 0; t < 2; t++) begin
            tick();
            n_cmp++;
            if (dut_vec !== 46'h0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h want 0", dut_vec);
            end
        end
        n_cmp++;
        if (fsm_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want %0d", fsm_state, IDLE);
        end
    endtask

    task automatic test_single_digit();
        int pulses = 0;
        int at     = -1;
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (update === 1'b1) begin pulses++; at = t; end
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_tick%0d: got %h want %h", t, dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if (pulses != 1 || at != S) begin
            n_fail++;
            $display("FAIL single_pulse: got %0d pulses at edge %0d want 1 at %0d", pulses, at, S);
        end
        n_cmp++;
        if ({digit_val[11:8], digit_valid[2], dp_val[2], update_idx} !== {4'h4, 1'b1, 1'b1, 3'd2}) begin
            n_fail++;
            $display("FAIL single_digit2: got val %h valid %b dp %b idx %0d want 4 1 1 2",
                     digit_val[11:8], digit_valid[2], dp_val[2], update_idx);
        end
    endtask

    task automatic test_toggle();
        logic [7:0] seq [6] = '{8'hC0, 8'hC0, 8'hF9, 8'hF9, 8'hC0, 8'hC0};
        for (int t = 0; t < 6; t++) begin
            drive(6'b000001, seq[t], 1'b1, 1'b0);
            tick();
            n_cmp++;
            if (update !== 1'b0 || dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL toggle_tick%0d: got %h want %h (no update)", t, dut_vec, exp_vec());
            end
        end
        drive(6'b000001, 8'hF9, 1'b1, 1'b0);
        for (int t = 0; t < 6; t++) begin
            tick();
            n_cmp++;
            if (update !== (t == S) || dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL toggle_hold%0d: got %h want %h", t, dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if ({digit_val[3:0], dp_val[0], digit_valid[0]} !== {4'h1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL toggle_digit0: got val %h dp %b valid %b want 1 0 1",
                     digit_val[3:0], dp_val[0], digit_valid[0]);
        end
    endtask

    task automatic test_scan();
        logic [2:0] exp_q[$];
        for (int d = 0; d < N; d++) begin
            drive(6'(1 << d), {1'b0, glyph[d]}, 1'b1, 1'b0);
            exp_q.push_back(3'(d));
            for (int t = 0; t < 5; t++) begin
                tick();
                if (update === 1'b1) begin
                    n_cmp++;
                    if (exp_q.size() == 0 || update_idx !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL scan_idx: got %0d want digit %0d", update_idx, d);
                    end
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                n_cmp++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL scan_d%0d_t%0d: got %h want %h", d, t, dut_vec, exp_vec());
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scan_pulses: got %0d missing pulses want 0", exp_q.size());
        end
        n_cmp++;
        if ({digit_val, dp_val, digit_valid} !== {24'h543210, 6'h3F, 6'h3F}) begin
            n_fail++;
            $display("FAIL scan_final: got %h %h %h want 543210 3f 3f", digit_val, dp_val, digit_valid);
        end
    endtask

    task automatic test_blank_bad();
        drive(6'b001000, 8'hFF, 1'b1, 1'b0);
        for (int t = 0; t < 5; t++) tick();
        n_cmp++;
        if ({digit_valid[3], bad_pattern[3], dp_val[3], digit_val[15:12]} !== {1'b0, 1'b0, 1'b0, 4'h3}) begin
            n_fail++;
            $display("FAIL blank_digit3: got valid %b bad %b dp %b val %h want 0 0 0 3",
                     digit_valid[3], bad_pattern[3], dp_val[3], digit_val[15:12]);
        end
        drive(6'b001000, 8'h7E, 1'b1, 1'b0);
        for (int t = 0; t < 5; t++) tick();
        n_cmp++;
        if ({digit_valid[3], bad_pattern[3], dp_val[3], digit_val[15:12]} !== {1'b0, 1'b1, 1'b1, 4'h3}) begin
            n_fail++;
            $display("FAIL illegal_digit3: got valid %b bad %b dp %b val %h want 0 1 1 3",
                     digit_valid[3], bad_pattern[3], dp_val[3], digit_val[15:12]);
        end
        drive(6'b001000, 8'h7E, 1'b0, 1'b1);
        tick();
        drive(6'b001000, 8'h7E, 1'b0, 1'b0);
        n_cmp++;
        if (bad_pattern !== 6'h00 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL err_clr: got bad %b want 000000", bad_pattern);
        end
        // Re-flag digit 3, then let err_clr meet a fresh bad capture on digit 4.
        drive(6'b001000, 8'h7E, 1'b1, 1'b0);
        for (int t = 0; t < 5; t++) tick();
        drive(6'b010000, 8'h7E, 1'b1, 1'b0);
        for (int t = 0; t < 5; t++) begin
            err_clr = (t == S);
            tick();
        end
        err_clr = 1'b0;
        n_cmp++;
        if (bad_pattern !== 6'b010000 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL clr_vs_set: got bad %b want 010000", bad_pattern);
        end
    endtask

    task automatic test_idle_cases();
        int first = -1;
        for (int t = 0; t < 20; t++) begin
            if (t < 10) drive(6'b000011, 8'h19, 1'b1, 1'b0);
            else        drive(6'b000100, 8'h19, 1'b0, 1'b0);
            tick();
            n_cmp++;
            if (update !== 1'b0 || fsm_state !== IDLE || dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL idle_t%0d: got upd %b state %0d want 0 %0d", t, update, fsm_state, IDLE);
            end
        end
        // Reset in the middle of a settle window.
        drive(6'b000001, 8'hA4, 1'b1, 1'b0);
        for (int t = 0; t < 3; t++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (update === 1'b1 && first < 0) first = t;
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL rst_mid_t%0d: got %h want %h", t, dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if (first != S) begin
            n_fail++;
            $display("FAIL rst_mid_latency: got first update at %0d want %0d", first, S);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] sel;
        logic [7:0]   seg;
        int           hold;
        int           kind;
        for (int seg_n = 0; seg_n < 80; seg_n++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0)      sel = 6'($urandom_range(0, 63));
            else                sel = 6'(1 << $urandom_range(0, N - 1));
            kind = $urandom_range(0, 9);
            if (kind < 7)       seg = {1'($urandom_range(0, 1)), glyph[$urandom_range(0, 15)]};
            else if (kind == 7) seg = {1'($urandom_range(0, 1)), 7'h7F};
            else                seg = 8'($urandom_range(0, 255));
            hold = $urandom_range(1, 8);
            for (int t = 0; t < hold; t++) begin
                drive(sel, seg, ($urandom_range(0, 19) != 0), ($urandom_range(0, 14) == 0));
                rst = ($urandom_range(0, 99) == 0);
                tick();
                n_cmp++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL random_s%0d_t%0d: got %h want %h", seg_n, t, dut_vec, exp_vec());
                end
            end
        end
        rst = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        drive('0, 8'hFF, 1'b0, 1'b0);
        test_reset();
        test_single_digit();
        test_toggle();
        test_scan();
        test_blank_bad();
        test_idle_cases();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
